// File: rtl/spi_slave.sv
// SPI slave with parameterised CPOL/CPHA, single-word transmit buffer and
// sticky receive-overrun flag. All SPI inputs are resynchronised to clk.
module spi_slave #(
    parameter int unsigned CPOL       = 0,
    parameter int unsigned CPHA       = 0,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_din,
    input  logic                  tx_wr_en,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_dout,
    output logic                  rx_valid,
    output logic                  rx_overrun,
    input  logic                  rx_ack
);

    localparam int unsigned     CntW       = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit    = CntW'(DATA_WIDTH - 1);
    localparam logic            SclkIdle   = 1'(CPOL);
    localparam bit              SampleRise = (CPOL == CPHA);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    state_e                state_q, state_d;
    logic                  cs_meta_q, cs_sync_q, cs_prev_q;
    logic                  sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic                  mosi_meta_q, mosi_sync_q;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_ready_q, tx_ready_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] rx_dout_q, rx_dout_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;

    logic cs_fall, sclk_rise, sclk_fall, sample_edge, shift_edge;
    logic do_sample, do_shift, word_done, reload, advance, load, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            sclk_meta_q <= SclkIdle;
            sclk_sync_q <= SclkIdle;
            sclk_prev_q <= SclkIdle;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            cs_meta_q   <= cs;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign cs_fall     = cs_prev_q & ~cs_sync_q;
    assign sclk_rise   = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_sync_q & sclk_prev_q;
    assign sample_edge = SampleRise ? sclk_rise : sclk_fall;
    assign shift_edge  = SampleRise ? sclk_fall : sclk_rise;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cs_fall) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: state_d = StShift;
            default: state_d = StIdle;
        endcase
        if (cs_sync_q) state_d = StIdle;
    end

    // A shift edge at count 0 is either the word boundary (CPHA=0, reload) or the
    // edge that merely presents the already-loaded MSB (CPHA=1); neither advances.
    assign do_sample = (state_q == StShift) & sample_edge;
    assign do_shift  = (state_q == StShift) & shift_edge;
    assign word_done = do_sample & (bit_cnt_q == LastBit);
    assign reload    = (CPHA == 0) ? (do_shift & (bit_cnt_q == '0)) : word_done;
    assign advance   = do_shift & (bit_cnt_q != '0);
    assign load      = (state_q == StLoad) | reload;
    assign accept    = tx_wr_en & (tx_ready_q | load);

    always_comb begin
        tx_sr_d    = tx_sr_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        rx_dout_d  = rx_dout_q;
        rx_valid_d = word_done;
        if (load) begin
            tx_sr_d = tx_ready_q ? '0 : tx_buf_q;
        end else if (advance) begin
            tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
        end
        if (do_sample) begin
            rx_sr_d   = {rx_sr_q[DATA_WIDTH-2:0], mosi_sync_q};
            bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
        end
        if (word_done) rx_dout_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_sync_q};
        if (state_q != StShift) bit_cnt_d = '0;

        tx_buf_d   = accept ? tx_din : tx_buf_q;
        tx_ready_d = accept ? 1'b0 : (load ? 1'b1 : tx_ready_q);

        pending_d = rx_valid_q ? 1'b1 : (rx_ack ? 1'b0 : pending_q);
        overrun_d = (rx_valid_q & pending_q) ? 1'b1 : (rx_ack ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            tx_buf_q   <= '0;
            tx_ready_q <= 1'b1;
            rx_sr_q    <= '0;
            rx_dout_q  <= '0;
            rx_valid_q <= 1'b0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            tx_buf_q   <= tx_buf_d;
            tx_ready_q <= tx_ready_d;
            rx_sr_q    <= rx_sr_d;
            rx_dout_q  <= rx_dout_d;
            rx_valid_q <= rx_valid_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
        end
    end

    assign miso       = (state_q != StIdle) & tx_sr_q[DATA_WIDTH-1];
    assign tx_ready   = tx_ready_q;
    assign rx_dout    = rx_dout_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode, a vector table for
// single-word frames, and hand-written multi-word, abort and reset sequences.
module tb_spi_slave;

    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cs, sclk, mosi, miso, tx_wr_en, tx_ready, rx_valid, rx_overrun, rx_ack;
    logic [7:0] tx_din  [4];
    logic [7:0] rx_dout [4];
    int         vcnt    [4] = '{default: 0};
    int         n_applied = 0;
    int         n_miscmp  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .CPOL       (g / 2),
            .CPHA       (g % 2),
            .DATA_WIDTH (8)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cs         (cs[g]),
            .sclk       (sclk[g]),
            .mosi       (mosi[g]),
            .miso       (miso[g]),
            .tx_din     (tx_din[g]),
            .tx_wr_en   (tx_wr_en[g]),
            .tx_ready   (tx_ready[g]),
            .rx_dout    (rx_dout[g]),
            .rx_valid   (rx_valid[g]),
            .rx_overrun (rx_overrun[g]),
            .rx_ack     (rx_ack[g])
        );
    end

    // Counts cycles with rx_valid high, so a stretched pulse shows up as extra.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_valid[k] === 1'b1) vcnt[k] <= vcnt[k] + 1;
        end
    end

    typedef struct {
        int         mode;
        logic [7:0] tx;
        logic [7:0] mosi_w;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [6];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_tx(input int m, input logic [7:0] v);
        tx_din[m]   = v;
        tx_wr_en[m] = 1'b1;
        wait_clk(1);
        tx_wr_en[m] = 1'b0;
    endtask

    task automatic ack(input int m);
        rx_ack[m] = 1'b1;
        wait_clk(1);
        rx_ack[m] = 1'b0;
    endtask

    // Master side: words packed {word0, word1}; last word may be truncated.
    task automatic frame(input int m, input int nwords, input logic [15:0] words,
                         input int last_bits, input bit refill, input logic [7:0] refill_val,
                         output logic [15:0] got);
        logic cpol, cpha, b;
        int   nb, idx;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        got  = '0;
        cs[m] = 1'b0;
        for (int w = 0; w < nwords; w++) begin
            nb = (w == nwords - 1) ? last_bits : 8;
            for (int i = 0; i < nb; i++) begin
                idx = (1 - w) * 8 + 7 - i;
                b   = words[idx];
                if (!cpha) mosi[m] = b;
                if (refill && w == 0 && i == 3) begin
                    write_tx(m, refill_val);
                    wait_clk(H - 1);
                end else begin
                    wait_clk(H);
                end
                if (!cpha) begin
                    got[idx] = miso[m];
                    sclk[m]  = ~cpol;
                    wait_clk(H);
                    sclk[m]  = cpol;
                end else begin
                    sclk[m] = ~cpol;
                    mosi[m] = b;
                    wait_clk(H);
                    got[idx] = miso[m];
                    sclk[m]  = cpol;
                end
            end
        end
        wait_clk(H);
        cs[m]   = 1'b1;
        mosi[m] = 1'b0;
        wait_clk(5);
    endtask

    initial begin
        logic [15:0] got;
        int          v0, m;

        vecs[0] = '{0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[2] = '{2, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[3] = '{3, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[4] = '{0, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[5] = '{3, 8'h0F, 8'hF0, 8'h0F, 8'hF0};

        cs       = 4'b1111;
        sclk     = 4'b1100;
        mosi     = '0;
        tx_wr_en = '0;
        rx_ack   = '0;
        for (int k = 0; k < 4; k++) tx_din[k] = '0;
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);

        check("rst_miso",       16'(miso[0]),       16'h0);
        check("rst_tx_ready",   16'(tx_ready[0]),   16'h1);
        check("rst_rx_dout",    16'(rx_dout[0]),    16'h0);
        check("rst_rx_valid",   16'(rx_valid[0]),   16'h0);
        check("rst_rx_overrun", 16'(rx_overrun[0]), 16'h0);

        for (int i = 0; i < 6; i++) begin
            m = vecs[i].mode;
            write_tx(m, vecs[i].tx);
            check($sformatf("v%0d_tx_full", i), 16'(tx_ready[m]), 16'h0);
            v0 = vcnt[m];
            frame(m, 1, {vecs[i].mosi_w, 8'h00}, 8, 1'b0, 8'h00, got);
            check($sformatf("v%0d_miso", i),     {8'h00, got[15:8]}, 16'(vecs[i].exp_miso));
            check($sformatf("v%0d_rx_dout", i),  16'(rx_dout[m]),    16'(vecs[i].exp_rx));
            check($sformatf("v%0d_rx_valid", i), 16'(vcnt[m] - v0),  16'h1);
            check($sformatf("v%0d_tx_ready", i), 16'(tx_ready[m]),   16'h1);
            check($sformatf("v%0d_idle_miso", i), 16'(miso[m]),      16'h0);
            ack(m);
        end

        // Two words back to back, buffer refilled during the first.
        write_tx(0, 8'hC3);
        v0 = vcnt[0];
        frame(0, 2, 16'h1122, 8, 1'b1, 8'h55, got);
        check("refill_miso",     got,                     16'hC355);
        check("refill_valids",   16'(vcnt[0] - v0),       16'h2);
        check("refill_rx_dout",  16'(rx_dout[0]),         16'h22);
        check("overrun_set",     16'(rx_overrun[0]),      16'h1);
        ack(0);
        check("overrun_clear",   16'(rx_overrun[0]),      16'h0);

        // Two words, no refill: second word must be zeros.
        write_tx(0, 8'h9A);
        frame(0, 2, 16'h3344, 8, 1'b0, 8'h00, got);
        check("norefill_miso",   got,                     16'h9A00);
        check("norefill_rx",     16'(rx_dout[0]),         16'h44);

        // Abort after 5 bits, then a clean frame.
        v0 = vcnt[0];
        frame(0, 1, 16'hFF00, 5, 1'b0, 8'h00, got);
        check("abort_valids",    16'(vcnt[0] - v0),       16'h0);
        check("abort_rx_dout",   16'(rx_dout[0]),         16'h44);
        write_tx(0, 8'h6B);
        v0 = vcnt[0];
        frame(0, 1, 16'hD200, 8, 1'b0, 8'h00, got);
        check("post_abort_miso", {8'h00, got[15:8]},      16'h6B);
        check("post_abort_rx",   16'(rx_dout[0]),         16'hD2);
        check("post_abort_vld",  16'(vcnt[0] - v0),       16'h1);

        // Reset in the middle of a word.
        write_tx(0, 8'hE7);
        cs[0]   = 1'b0;
        mosi[0] = 1'b1;
        wait_clk(H);
        sclk[0] = 1'b1;
        wait_clk(H);
        sclk[0] = 1'b0;
        write_tx(0, 8'h12);
        wait_clk(H - 1);
        sclk[0] = 1'b1;
        wait_clk(H);
        sclk[0] = 1'b0;
        wait_clk(2);
        check("pre_rst_tx_ready", 16'(tx_ready[0]),   16'h0);
        check("pre_rst_overrun",  16'(rx_overrun[0]), 16'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso",     16'(miso[0]),       16'h0);
        check("mid_rst_tx_ready", 16'(tx_ready[0]),   16'h1);
        check("mid_rst_rx_dout",  16'(rx_dout[0]),    16'h0);
        check("mid_rst_rx_valid", 16'(rx_valid[0]),   16'h0);
        check("mid_rst_overrun",  16'(rx_overrun[0]), 16'h0);
        wait_clk(1);
        cs[0]   = 1'b1;
        sclk[0] = 1'b0;
        mosi[0] = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        wait_clk(4);
        write_tx(0, 8'h5C);
        v0 = vcnt[0];
        frame(0, 1, 16'h9600, 8, 1'b0, 8'h00, got);
        check("post_rst_rx",      16'(rx_dout[0]),    16'h96);
        check("post_rst_miso",    {8'h00, got[15:8]}, 16'h5C);
        check("post_rst_valid",   16'(vcnt[0] - v0),  16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter CPOL, default 0, SCLK idle level (0-1).
REQ-002 Parameter CPHA, default 0, 0 = sample on first SCLK edge, 1 = sample on second edge (0-1).
REQ-003 Parameter DATA_WIDTH, default 8, bits per word, >= 2.
REQ-004 Port clk, input, 1, system clock; all logic on rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port cs, input, 1, chip select from master, active low, asynchronous to clk.
REQ-007 Port sclk, input, 1, serial clock from master, asynchronous to clk.
REQ-008 Port mosi, input, 1, serial data from master.
REQ-009 Port miso, output, 1, serial data to master.
REQ-010 Port tx_din, input, DATA_WIDTH, next word to transmit.
REQ-011 Port tx_wr_en, input, 1, load tx_din into transmit buffer.
REQ-012 Port tx_ready, output, 1, transmit buffer empty.
REQ-013 Port rx_dout, output, DATA_WIDTH, last received word.
REQ-014 Port rx_valid, output, 1, one-cycle pulse, rx_dout updated.
REQ-015 Port rx_overrun, output, 1, sticky, word received while previous one was unread (cleared by rx_ack).
REQ-016 Port rx_ack, input, 1, consumer has read rx_dout.

Function
REQ-017 cs, sclk, mosi SHALL each pass a 2-flop synchronizer; edges are detected on synchronized values (3rd flop compare).
REQ-018 Sample edge SHALL be rising when CPOL==CPHA, falling otherwise; shift edge is the opposite edge.
REQ-019 Correct operation requires each SCLK level to last >= 4 clk cycles; a master half-period of >= 4 clk cycles is the supported range.
REQ-020 Data SHALL be MSB first in both directions.
REQ-021 FSM states: IDLE, LOAD, SHIFT; IDLE->LOAD on synchronized cs falling edge; LOAD->SHIFT after one cycle; SHIFT->IDLE on synchronized cs high; cs high in any state forces IDLE next cycle.
REQ-022 LOAD SHALL copy transmit buffer into tx shift register and set tx_ready=1 if buffer was full, else load all-zeros; bit counter cleared.
REQ-023 CPHA=0: miso SHALL present tx MSB from LOAD onward, before the first sample edge; CPHA=1: first shift edge presents MSB.
REQ-024 Each sample edge SHALL shift mosi into rx shift register and increment bit counter; each shift edge (except the CPHA=0 shift edge that follows the last sample of a word is the word boundary, see REQ-026) advances tx shift register by one.
REQ-025 On the DATA_WIDTH-th sample edge: rx_dout <= assembled word, rx_valid pulses the following cycle for exactly one cycle, bit counter wraps to 0.
REQ-026 If cs stays low after a full word, the next word SHALL start without reloading via IDLE: tx shift register reloads from buffer (or zeros) at the word boundary, same rules as REQ-022.
REQ-027 cs rising mid-word SHALL discard the partial word: no rx_valid, rx_dout unchanged, counter cleared.
REQ-028 miso SHALL be 0 whenever FSM is IDLE.
REQ-029 tx_wr_en while tx_ready=1: buffer <= tx_din, tx_ready=0 next cycle; tx_wr_en while tx_ready=0: ignored, buffer unchanged.
REQ-030 tx_wr_en in the same cycle as a buffer-to-shift-register load: load takes old contents (if full) or zeros, then new word enters buffer; tx_ready ends 0.
REQ-031 rx_overrun SHALL set when rx_valid pulses and no rx_ack occurred since the previous rx_valid; rx_ack and set in the same cycle: set wins.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, miso 0, tx_ready 1, rx_dout 0, rx_valid 0, rx_overrun 0, shift registers, counters, synchronizers 0 (sclk synchronizer to CPOL, cs synchronizer to 1).
REQ-033 Reset during SHIFT SHALL abort the word; after release no edge is detected until a new cs falling edge.

Verification
REQ-034 Mode 0, DATA_WIDTH=8, tx_din=0xA5 preloaded, master sends 0x3C with half-period 5 clk -> miso bits 1,0,1,0,0,1,0,1; rx_dout=0x3C, one rx_valid pulse, tx_ready=1 after LOAD.
REQ-035 Modes 1, 2, 3 each with tx 0x81, rx 0x7E -> same data in both directions, no spurious sample on first edge for CPHA=1.
REQ-036 cs held low for 2 words, buffer refilled with 0x55 between -> miso second word 0x55, two rx_valid pulses; buffer not refilled -> second word 0x00.
REQ-037 cs raised after 5 bits -> no rx_valid, rx_dout unchanged, next full frame received correctly.
REQ-038 Two words received without rx_ack -> rx_overrun=1 after second rx_valid; rx_ack -> 0.
REQ-039 rst_n asserted mid-word -> all outputs at REQ-032 values in same cycle; subsequent frame 0x96 received correctly.
